// File: rtl/bus_pkg.sv
// Shared bus definitions: command encodings and arbiter FSM states,
// common to the arbiter, the memory controller and the cache blocks.
package bus_pkg;

  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'b00,
    CMD_READ      = 2'b01,
    CMD_UPGRADE   = 2'b10,
    CMD_WRITEBACK = 2'b11
  } bus_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_e;

  // Only reads need a data phase from memory; upgrades and writebacks
  // complete straight after the bus cycle.
  function automatic logic cmd_is_read(input logic [1:0] cmd);
    return cmd == CMD_READ;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of requester, snoop, memory and shared-bus signals around the
// arbiter. The master modport is the arbiter itself (it owns the shared
// bus); the slave modport is the surrounding caches and memory.
interface bus_arbiter_if #(
  parameter int ADDR_BITS  = 8,
  parameter int LINE_WORDS = 4,
  parameter int N_MASTERS  = 4
);
  import bus_pkg::*;

  localparam int LINE_BITS = LINE_WORDS * WORD_BITS;

  logic [N_MASTERS-1:0]           req;
  logic [N_MASTERS*ADDR_BITS-1:0] req_addr;
  logic [N_MASTERS*2-1:0]         req_cmd;
  logic [N_MASTERS*LINE_BITS-1:0] req_wdata;
  logic                           snoop_dirty;
  logic [LINE_BITS-1:0]           snoop_data;
  logic [LINE_BITS-1:0]           mem_rdata;
  logic                           mem_valid;

  logic [N_MASTERS-1:0]           gnt;
  logic [N_MASTERS-1:0]           done;
  logic                           err;
  logic [LINE_BITS-1:0]           resp_data;
  logic                           bus_valid;
  logic [ADDR_BITS-1:0]           bus_addr;
  logic [1:0]                     bus_cmd;
  logic [LINE_BITS-1:0]           bus_wdata;
  logic                           bus_dirty;

  modport master (
    input  req, req_addr, req_cmd, req_wdata,
    input  snoop_dirty, snoop_data, mem_rdata, mem_valid,
    output gnt, done, err, resp_data,
    output bus_valid, bus_addr, bus_cmd, bus_wdata, bus_dirty
  );

  modport slave (
    output req, req_addr, req_cmd, req_wdata,
    output snoop_dirty, snoop_data, mem_rdata, mem_valid,
    input  gnt, done, err, resp_data,
    input  bus_valid, bus_addr, bus_cmd, bus_wdata, bus_dirty
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin selector: scans the request vector starting at ptr and
// wrapping past the top master, returning the first requester one-hot.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);

  logic             found;
  logic [PTR_W-1:0] idx;
  int               pos;

  // First requester at or above ptr (modulo N) wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    pos    = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = PTR_W'(pos);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: grants one cache requester at a time, issues its
// command on the shared bus for one cycle, collects the line from a dirty
// snooper or from memory (with a timeout), and pulses done to the owner.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int LINE_WORDS = 4,
  parameter int N_MASTERS  = 4,
  parameter int TIMEOUT    = 15
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.master bus
);

  localparam int LINE_BITS = LINE_WORDS * WORD_BITS;
  localparam int PTR_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  arb_state_e               state_q, state_d;
  logic [N_MASTERS-1:0]     gnt_q, gnt_d;
  logic [N_MASTERS-1:0]     done_q, done_d;
  logic                     err_q, err_d;
  logic [LINE_BITS-1:0]     resp_data_q, resp_data_d;
  logic                     bus_valid_q, bus_valid_d;
  logic [ADDR_BITS-1:0]     bus_addr_q, bus_addr_d;
  logic [1:0]               bus_cmd_q, bus_cmd_d;
  logic [LINE_BITS-1:0]     bus_wdata_q, bus_wdata_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;

  logic [N_MASTERS-1:0]     winner;
  logic [ADDR_BITS-1:0]     sel_addr;
  logic [1:0]               sel_cmd;
  logic [LINE_BITS-1:0]     sel_wdata;
  logic [PTR_W-1:0]         ptr_next;

  rr_picker #(
    .N     (N_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (winner)
  );

  // Mux the winner's request fields and compute the pointer just above it.
  always_comb begin
    sel_addr  = '0;
    sel_cmd   = '0;
    sel_wdata = '0;
    ptr_next  = ptr_q;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (winner[i]) begin
        sel_addr  = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_cmd   = bus.req_cmd[i*2 +: 2];
        sel_wdata = bus.req_wdata[i*LINE_BITS +: LINE_BITS];
        ptr_next  = (i == N_MASTERS - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Transaction FSM: grant in IDLE, one bus cycle in ISSUE, data phase in WAIT, done pulse in RESP.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    resp_data_d = resp_data_q;
    bus_valid_d = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_cmd_d   = bus_cmd_q;
    bus_wdata_d = bus_wdata_q;
    ptr_d       = ptr_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d     = ST_ISSUE;
          gnt_d       = winner;
          bus_valid_d = 1'b1;
          bus_addr_d  = sel_addr;
          bus_cmd_d   = sel_cmd;
          bus_wdata_d = sel_wdata;
          ptr_d       = ptr_next;
        end
      end
      ST_ISSUE: begin
        if (cmd_is_read(bus_cmd_q)) begin
          if (bus.snoop_dirty) begin
            resp_data_d = bus.snoop_data;
            done_d      = gnt_q;
            state_d     = ST_RESP;
          end else begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
          end
        end else begin
          done_d  = gnt_q;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (bus.mem_valid) begin
          resp_data_d = bus.mem_rdata;
          done_d      = gnt_q;
          state_d     = ST_RESP;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_data_d = '0;
          err_d       = 1'b1;
          done_d      = gnt_q;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_cmd_q   <= '0;
      bus_wdata_q <= '0;
      ptr_q       <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_cmd_q   <= bus_cmd_d;
      bus_wdata_q <= bus_wdata_d;
      ptr_q       <= ptr_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.resp_data = resp_data_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_cmd   = bus_cmd_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_dirty = bus_valid_q & bus.snoop_dirty;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: drives cache requests step by step and
// plays a simple line memory that answers reads one cycle after the bus cycle.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        mem_valid_m;
  logic        stray_valid;
  logic        mem_enable;
  logic        mem_pend;
  int          pend_base;
  logic [31:0] mem [0:63];

  bus_arbiter_if #(.ADDR_BITS(8), .LINE_WORDS(4), .N_MASTERS(4)) bif ();

  bus_arbiter #(
    .ADDR_BITS  (8),
    .LINE_WORDS (4),
    .N_MASTERS  (4),
    .TIMEOUT    (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  assign bif.mem_valid = mem_valid_m | stray_valid;

  // Line memory: word k holds k after reset; writebacks store the line,
  // reads answer with mem_valid in the cycle after the bus cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 64; k++) mem[k] = k;
      mem_pend      = 1'b0;
      pend_base     = 0;
      mem_valid_m   = 1'b0;
      bif.mem_rdata = '0;
    end else begin
      mem_valid_m = 1'b0;
      if (mem_pend) begin
        mem_valid_m = 1'b1;
        for (int j = 0; j < 4; j++) bif.mem_rdata[j*32 +: 32] = mem[pend_base + j];
        mem_pend = 1'b0;
      end
      if (bif.bus_valid) begin
        if (bif.bus_cmd == 2'b11) begin
          for (int j = 0; j < 4; j++) mem[int'(bif.bus_addr[7:4]) * 4 + j] = bif.bus_wdata[j*32 +: 32];
        end else if (bif.bus_cmd == 2'b01 && !bif.snoop_dirty && mem_enable) begin
          mem_pend  = 1'b1;
          pend_base = int'(bif.bus_addr[7:4]) * 4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic [1:0] cmd, input logic [7:0] addr,
                               input logic [127:0] wdata);
    bif.req_cmd[m*2 +: 2]       = cmd;
    bif.req_addr[m*8 +: 8]      = addr;
    bif.req_wdata[m*128 +: 128] = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},       bif.gnt, 0);
    checkOutput({tag, "_done"},      bif.done, 0);
    checkOutput({tag, "_err"},       bif.err, 0);
    checkOutput({tag, "_resp_data"}, bif.resp_data, 0);
    checkOutput({tag, "_bus_valid"}, bif.bus_valid, 0);
    checkOutput({tag, "_bus_addr"},  bif.bus_addr, 0);
    checkOutput({tag, "_bus_cmd"},   bif.bus_cmd, 0);
    checkOutput({tag, "_bus_wdata"}, bif.bus_wdata, 0);
    checkOutput({tag, "_bus_dirty"}, bif.bus_dirty, 0);
  endtask

  initial begin
    logic [3:0] exp_gnt;

    rst             = 1'b0;
    stray_valid     = 1'b0;
    mem_enable      = 1'b1;
    bif.req         = '0;
    bif.req_addr    = '0;
    bif.req_cmd     = '0;
    bif.req_wdata   = '0;
    bif.snoop_dirty = 1'b0;
    bif.snoop_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkAllZero("reset");
    rst = 1'b1;
    tick();

    $display("[TB] contention, all masters upgrading");
    for (int m = 0; m < 4; m++) applyStimulus(m, 2'b10, 8'h40 + 8'(m * 16), '0);
    bif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      checkOutput("rr_gnt", bif.gnt, exp_gnt);
      checkOutput("rr_onehot", $onehot(bif.gnt), 1);
      checkOutput("rr_bus_valid", bif.bus_valid, 1);
      tick();
      checkOutput("rr_done", bif.done, exp_gnt);
      checkOutput("rr_bus_valid_low", bif.bus_valid, 0);
      if (k == 4) bif.req = 4'b0000;
      tick();
      checkOutput("rr_idle_gnt", bif.gnt, 0);
    end
    tick();
    checkOutput("rr_no_regrant", bif.bus_valid, 0);

    $display("[TB] single read, master 2");
    applyStimulus(2, 2'b01, 8'h14, '0);
    bif.req = 4'b0100;
    tick();
    checkOutput("rd_gnt", bif.gnt, 4'b0100);
    checkOutput("rd_bus_valid", bif.bus_valid, 1);
    checkOutput("rd_bus_addr", bif.bus_addr, 8'h14);
    checkOutput("rd_bus_cmd", bif.bus_cmd, 2'b01);
    checkOutput("rd_bus_dirty", bif.bus_dirty, 0);
    checkOutput("rd_done_c1", bif.done, 0);
    tick();
    checkOutput("rd_bus_valid_c2", bif.bus_valid, 0);
    checkOutput("rd_done_c2", bif.done, 0);
    checkOutput("rd_gnt_c2", bif.gnt, 4'b0100);
    tick();
    checkOutput("rd_done_c3", bif.done, 4'b0100);
    checkOutput("rd_err", bif.err, 0);
    checkOutput("rd_data", bif.resp_data, {32'd7, 32'd6, 32'd5, 32'd4});
    bif.req = 4'b0000;
    tick();
    checkOutput("rd_done_c4", bif.done, 0);
    checkOutput("rd_gnt_c4", bif.gnt, 0);

    $display("[TB] dirty supply, master 3");
    applyStimulus(3, 2'b01, 8'h30, '0);
    bif.snoop_dirty = 1'b1;
    bif.snoop_data  = {4{32'hA5A5A5A5}};
    bif.req         = 4'b1000;
    tick();
    checkOutput("dirty_gnt", bif.gnt, 4'b1000);
    checkOutput("dirty_bus_dirty", bif.bus_dirty, 1);
    tick();
    checkOutput("dirty_done_c2", bif.done, 4'b1000);
    checkOutput("dirty_data", bif.resp_data, {4{32'hA5A5A5A5}});
    checkOutput("dirty_bus_dirty_off", bif.bus_dirty, 0);
    bif.req         = 4'b0000;
    bif.snoop_dirty = 1'b0;
    tick();
    checkOutput("dirty_done_c3", bif.done, 0);

    $display("[TB] writeback, master 1");
    applyStimulus(1, 2'b11, 8'h20, {32'd6, 32'd7, 32'd8, 32'd9});
    bif.req = 4'b0010;
    tick();
    checkOutput("wb_gnt", bif.gnt, 4'b0010);
    checkOutput("wb_bus_cmd", bif.bus_cmd, 2'b11);
    checkOutput("wb_bus_addr", bif.bus_addr, 8'h20);
    checkOutput("wb_bus_wdata", bif.bus_wdata, {32'd6, 32'd7, 32'd8, 32'd9});
    tick();
    checkOutput("wb_done_c2", bif.done, 4'b0010);
    checkOutput("wb_err", bif.err, 0);
    bif.req = 4'b0000;
    tick();
    checkOutput("wb_done_c3", bif.done, 0);

    $display("[TB] read back written line, owner drops req early");
    applyStimulus(1, 2'b01, 8'h20, '0);
    bif.req = 4'b0010;
    tick();
    checkOutput("rb_gnt", bif.gnt, 4'b0010);
    bif.req = 4'b0000;
    tick();
    checkOutput("rb_done_c2", bif.done, 0);
    tick();
    checkOutput("rb_done_c3", bif.done, 4'b0010);
    checkOutput("rb_data", bif.resp_data, {32'd6, 32'd7, 32'd8, 32'd9});
    tick();
    checkOutput("rb_done_c4", bif.done, 0);

    $display("[TB] timeout, master 0");
    mem_enable = 1'b0;
    applyStimulus(0, 2'b01, 8'h00, '0);
    bif.req = 4'b0001;
    tick();
    checkOutput("to_gnt", bif.gnt, 4'b0001);
    repeat (15) tick();
    checkOutput("to_done_c16", bif.done, 0);
    checkOutput("to_err_c16", bif.err, 0);
    tick();
    checkOutput("to_done_c17", bif.done, 4'b0001);
    checkOutput("to_err_c17", bif.err, 1);
    checkOutput("to_data", bif.resp_data, 0);
    bif.req = 4'b0000;
    tick();
    checkOutput("to_done_c18", bif.done, 0);
    checkOutput("to_err_c18", bif.err, 0);
    stray_valid = 1'b1;
    tick();
    checkOutput("stray_done_a", bif.done, 0);
    tick();
    checkOutput("stray_done_b", bif.done, 0);
    checkOutput("stray_gnt", bif.gnt, 0);
    stray_valid = 1'b0;
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(2, 2'b01, 8'h14, '0);
    bif.req = 4'b0100;
    tick();
    checkOutput("rw_gnt", bif.gnt, 4'b0100);
    tick();
    rst     = 1'b0;
    bif.req = 4'b0000;
    #1;
    checkAllZero("rw_async");
    tick();
    checkOutput("rw_done_a", bif.done, 0);
    tick();
    checkOutput("rw_done_b", bif.done, 0);
    rst        = 1'b1;
    mem_enable = 1'b1;
    tick();

    $display("[TB] after reset, pointer back at master 0");
    applyStimulus(0, 2'b01, 8'h14, '0);
    applyStimulus(3, 2'b01, 8'h30, '0);
    bif.req = 4'b1001;
    tick();
    checkOutput("ar_gnt", bif.gnt, 4'b0001);
    checkOutput("ar_bus_addr", bif.bus_addr, 8'h14);
    tick();
    tick();
    checkOutput("ar_done", bif.done, 4'b0001);
    checkOutput("ar_data", bif.resp_data, {32'd7, 32'd6, 32'd5, 32'd4});
    bif.req = 4'b1000;
    tick();
    checkOutput("ar_done_off", bif.done, 0);
    tick();
    checkOutput("ar_gnt3", bif.gnt, 4'b1000);
    bif.req = 4'b0000;
    tick();
    tick();
    checkOutput("ar_done3", bif.done, 4'b1000);
    checkOutput("ar_data3", bif.resp_data, {32'd15, 32'd14, 32'd13, 32'd12});
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
